debounce_edge_fsm: RTL

// - Tick consumer for timer_parameter. Takes its periodic 'done' pulse as the sample tick.
// - Debounces one raw push-button input and emits a clean level plus one-cycle rise/fall pulses.
// - Drives the timer's enable. Sits between the pad input and user logic in the button path.

---
 rtl/debounce_edge_fsm_pkg.sv | 20 ++
 rtl/debounce_edge_fsm_sync_ff.sv | 39 +++
 rtl/debounce_edge_fsm.sv | 135 +++++++++++++
 3 files changed

// File: rtl/debounce_edge_fsm_pkg.sv
// -----------------------------------------------------------------------------
// debounce_edge_fsm_pkg
// Shared definitions for the push-button debouncer:
//   - state_e               : 2-bit FSM state encoding
//   - DEFAULT_STABLE_TICKS  : consecutive stable ticks needed to accept a level
//   - DEFAULT_SYNC_STAGES   : synchronizer depth on the raw button input
// -----------------------------------------------------------------------------
package debounce_edge_fsm_pkg;

    typedef enum logic [1:0] {
        ZERO  = 2'd0,   // debounced level is 0, idle
        WAIT1 = 2'd1,   // qualifying a 0->1 change
        ONE   = 2'd2,   // debounced level is 1, idle
        WAIT0 = 2'd3    // qualifying a 1->0 change
    } state_e;

    localparam int unsigned DEFAULT_STABLE_TICKS = 4;
    localparam int unsigned DEFAULT_SYNC_STAGES  = 2;

endpackage : debounce_edge_fsm_pkg

// File: rtl/debounce_edge_fsm_sync_ff.sv
// -----------------------------------------------------------------------------
// sync_ff
// Generic N-flop synchronizer for a single asynchronous bit.
// Ports:
//   clk     in  system clock
//   reset_n in  asynchronous active-low reset, clears every stage to 0
//   d       in  asynchronous input
//   q       out synchronized output, STAGES clocks of latency
// -----------------------------------------------------------------------------
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the raw input in at bit 0; the oldest sample leaves at the top.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // NOTE: clocked state is assigned with <= so every flop samples the
    // pre-edge value of its neighbour; '=' here would collapse the chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule : sync_ff

// File: rtl/debounce_edge_fsm.sv
// -----------------------------------------------------------------------------
// debounce_edge_fsm
// Debounces one raw push-button input using an external periodic sample tick
// and produces a clean level plus one-clock rise/fall pulses. A new level is
// accepted only after STABLE_TICKS consecutive ticks with the synchronized
// input unchanged; any bounce restarts qualification from zero.
// Ports:
//   clk       in  system clock, rising edge
//   reset_n   in  asynchronous active-low reset
//   btn_in    in  raw asynchronous button level
//   tick      in  one-clock sample strobe (from the parent's timer 'done')
//   timer_en  out enable for the external timer, high while qualifying
//   busy      out high while in WAIT1 or WAIT0
//   db_level  out registered debounced level
//   rise_tick out one-clock pulse on db_level 0->1
//   fall_tick out one-clock pulse on db_level 1->0
// -----------------------------------------------------------------------------
module debounce_edge_fsm
    import debounce_edge_fsm_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = DEFAULT_STABLE_TICKS,
    parameter int unsigned SYNC_STAGES  = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_in,
    input  logic tick,
    output logic timer_en,
    output logic busy,
    output logic db_level,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int unsigned          CNT_W    = $clog2(STABLE_TICKS + 1);
    // Count value at which the next tick is the accepting one.
    localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(STABLE_TICKS - 1);

    logic             btn_sync;
    state_e           state_q,    state_d;
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic             db_level_q, db_level_d;
    logic             rise_q,     rise_d;
    logic             fall_q,     fall_d;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (btn_in),
        .q       (btn_sync)
    );

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        db_level_d = db_level_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;

        case (state_q)
            ZERO: begin
                if (btn_sync) begin
                    state_d    = WAIT1;
                    tick_cnt_d = '0;
                end
            end
            WAIT1: begin
                // A bounce back to 0 takes priority over a coincident tick.
                if (!btn_sync) begin
                    state_d = ZERO;
                end else if (tick) begin
                    if (tick_cnt_q == LAST_CNT) begin
                        state_d    = ONE;
                        db_level_d = 1'b1;
                        rise_d     = 1'b1;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            ONE: begin
                if (!btn_sync) begin
                    state_d    = WAIT0;
                    tick_cnt_d = '0;
                end
            end
            WAIT0: begin
                if (btn_sync) begin
                    state_d = ONE;
                end else if (tick) begin
                    if (tick_cnt_q == LAST_CNT) begin
                        state_d    = ZERO;
                        db_level_d = 1'b0;
                        fall_d     = 1'b1;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ZERO;
            end
        endcase
    end

    // NOTE: all control state resets asynchronously so an abort mid-
    // qualification leaves no stale count or half-emitted pulse behind.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ZERO;
            tick_cnt_q <= '0;
            db_level_q <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            db_level_q <= db_level_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
        end
    end

    // The timer only runs while a change is being qualified.
    assign busy      = (state_q == WAIT1) || (state_q == WAIT0);
    assign timer_en  = busy;
    assign db_level  = db_level_q;
    assign rise_tick = rise_q;
    assign fall_tick = fall_q;

endmodule : debounce_edge_fsm
